seg_display_driver: RTL and testbench

//  MMIO write responder for the 7-segment display: the device end of the SegCtrl/write_data path

---
 rtl/seg_display_driver_pkg.sv | 25 ++
 rtl/seg_display_driver_hex_to_seg.sv | 35 +++
 rtl/seg_display_driver.sv | 106 ++++++++++
 tb/tb_seg_display_driver.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/seg_display_driver_pkg.sv
// Shared constants for the 7-segment display driver.
// Glyph bytes are active-high in {dp,g,f,e,d,c,b,a} order; dp is never lit.
// The MMIO base address of the display lives with the other IO addresses
// and is not repeated here.
package seg_display_driver_pkg;

   localparam logic [7:0] SEG_0     = 8'h3F;
   localparam logic [7:0] SEG_1     = 8'h06;
   localparam logic [7:0] SEG_2     = 8'h5B;
   localparam logic [7:0] SEG_3     = 8'h4F;
   localparam logic [7:0] SEG_4     = 8'h66;
   localparam logic [7:0] SEG_5     = 8'h6D;
   localparam logic [7:0] SEG_6     = 8'h7D;
   localparam logic [7:0] SEG_7     = 8'h07;
   localparam logic [7:0] SEG_8     = 8'h7F;
   localparam logic [7:0] SEG_9     = 8'h6F;
   localparam logic [7:0] SEG_A     = 8'h77;
   localparam logic [7:0] SEG_B     = 8'h7C;  // lowercase b
   localparam logic [7:0] SEG_C     = 8'h39;
   localparam logic [7:0] SEG_D     = 8'h5E;  // lowercase d
   localparam logic [7:0] SEG_E     = 8'h79;
   localparam logic [7:0] SEG_F     = 8'h71;
   localparam logic [7:0] SEG_BLANK = 8'h00;

endpackage

// File: rtl/seg_display_driver_hex_to_seg.sv
// hex_to_seg: combinational hex nibble to 7-segment glyph decoder.
// Ports:
//   digit_i  4-bit hex digit
//   glyph_o  8-bit segment byte {dp,g,f,e,d,c,b,a}, active-high
module hex_to_seg
   import seg_display_driver_pkg::*;
(
   input  logic [3:0] digit_i,
   output logic [7:0] glyph_o
);

   always_comb begin
      glyph_o = SEG_BLANK;
      unique case (digit_i)
         4'h0: glyph_o = SEG_0;
         4'h1: glyph_o = SEG_1;
         4'h2: glyph_o = SEG_2;
         4'h3: glyph_o = SEG_3;
         4'h4: glyph_o = SEG_4;
         4'h5: glyph_o = SEG_5;
         4'h6: glyph_o = SEG_6;
         4'h7: glyph_o = SEG_7;
         4'h8: glyph_o = SEG_8;
         4'h9: glyph_o = SEG_9;
         4'hA: glyph_o = SEG_A;
         4'hB: glyph_o = SEG_B;
         4'hC: glyph_o = SEG_C;
         4'hD: glyph_o = SEG_D;
         4'hE: glyph_o = SEG_E;
         4'hF: glyph_o = SEG_F;
         default: glyph_o = SEG_BLANK;
      endcase
   end

endmodule

// File: rtl/seg_display_driver.sv
// seg_display_driver: MMIO write responder for the 8-digit 7-segment display.
// Captures a 32-bit store on SegCtrl, holds it, and scans it as 8 hex digits
// over two 4-digit segment buses, one digit pair (i, i+4) at a time.
// Ports:
//   clk         system clock, rising edge
//   rst_n       async active-low reset (sync release expected from the system)
//   SegCtrl     one-cycle store strobe from the IO decoder
//   write_data  store data; digit i = write_data[4i+3:4i], digit 7 leftmost
//   seg_an      digit enables, active-high, bit i lights digit i
//   seg_out0    segment byte for digits 0-3
//   seg_out1    segment byte for digits 4-7
//   seg_value   currently held value
module seg_display_driver
   import seg_display_driver_pkg::*;
#(
   parameter int unsigned SCAN_DIV = 100000,
   parameter bit          LZ_BLANK = 1'b1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        SegCtrl,
   input  logic [31:0] write_data,
   output logic [7:0]  seg_an,
   output logic [7:0]  seg_out0,
   output logic [7:0]  seg_out1,
   output logic [31:0] seg_value
);

   localparam int unsigned CntW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam logic [CntW-1:0] CntMax = CntW'(SCAN_DIV - 1);

   logic [31:0]     seg_value_q, seg_value_d;
   logic [CntW-1:0] div_cnt_q, div_cnt_d;
   logic [1:0]      scan_idx_q, scan_idx_d;
   logic [7:0]      seg_an_q, seg_an_d;
   logic [7:0]      seg_out0_q, seg_out0_d;
   logic [7:0]      seg_out1_q, seg_out1_d;

   logic [2:0] lo_idx, hi_idx;
   logic [3:0] lo_digit, hi_digit;
   logic [7:0] lo_glyph, hi_glyph;
   logic [2:0] msd;  // index of the most significant nonzero digit (0 when value is 0)

   assign lo_idx   = {1'b0, scan_idx_q};
   assign hi_idx   = {1'b1, scan_idx_q};
   assign lo_digit = seg_value_q[{lo_idx, 2'b00} +: 4];
   assign hi_digit = seg_value_q[{hi_idx, 2'b00} +: 4];

   hex_to_seg u_dec_lo (
      .digit_i (lo_digit),
      .glyph_o (lo_glyph)
   );

   hex_to_seg u_dec_hi (
      .digit_i (hi_digit),
      .glyph_o (hi_glyph)
   );

   always_comb begin
      msd = 3'd0;
      for (int unsigned i = 1; i < 8; i++) begin
         if (seg_value_q[4*i +: 4] != 4'h0) msd = 3'(i);
      end
   end

   always_comb begin
      // Last write wins; a strobe on the wrap cycle still lands this cycle.
      seg_value_d = SegCtrl ? write_data : seg_value_q;

      div_cnt_d  = div_cnt_q + CntW'(1);
      scan_idx_d = scan_idx_q;
      if (div_cnt_q == CntMax) begin
         div_cnt_d  = '0;
         scan_idx_d = scan_idx_q + 2'd1;
      end

      // Anodes stay driven even when the digit is blanked.
      seg_an_d   = (8'd1 << lo_idx) | (8'd1 << hi_idx);
      seg_out0_d = (LZ_BLANK && (lo_idx > msd)) ? SEG_BLANK : lo_glyph;
      seg_out1_d = (LZ_BLANK && (hi_idx > msd)) ? SEG_BLANK : hi_glyph;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         seg_value_q <= '0;
         div_cnt_q   <= '0;
         scan_idx_q  <= '0;
         seg_an_q    <= '0;
         seg_out0_q  <= '0;
         seg_out1_q  <= '0;
      end else begin
         seg_value_q <= seg_value_d;
         div_cnt_q   <= div_cnt_d;
         scan_idx_q  <= scan_idx_d;
         seg_an_q    <= seg_an_d;
         seg_out0_q  <= seg_out0_d;
         seg_out1_q  <= seg_out1_d;
      end
   end

   assign seg_value = seg_value_q;
   assign seg_an    = seg_an_q;
   assign seg_out0  = seg_out0_q;
   assign seg_out1  = seg_out1_q;

endmodule

// File: tb/tb_seg_display_driver.sv
// Scoreboard bench for seg_display_driver. Two instances share the inputs:
// one with leading-zero blanking, one showing all digits.
module tb_seg_display_driver;

   localparam int unsigned Div = 4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        seg_ctrl = 1'b0;
   logic [31:0] write_data = '0;

   logic [7:0]  an_b, o0_b, o1_b, an_n, o0_n, o1_n;
   logic [31:0] val_b, val_n;

   always #5 clk = ~clk;

   seg_display_driver #(.SCAN_DIV(Div), .LZ_BLANK(1'b1)) dut_blank (
      .clk        (clk),
      .rst_n      (rst_n),
      .SegCtrl    (seg_ctrl),
      .write_data (write_data),
      .seg_an     (an_b),
      .seg_out0   (o0_b),
      .seg_out1   (o1_b),
      .seg_value  (val_b)
   );

   seg_display_driver #(.SCAN_DIV(Div), .LZ_BLANK(1'b0)) dut_all (
      .clk        (clk),
      .rst_n      (rst_n),
      .SegCtrl    (seg_ctrl),
      .write_data (write_data),
      .seg_an     (an_n),
      .seg_out0   (o0_n),
      .seg_out1   (o1_n),
      .seg_value  (val_n)
   );

   typedef struct {
      logic [7:0]  an;
      logic [7:0]  b0, b1;   // blanking instance
      logic [7:0]  n0, n1;   // non-blanking instance
      logic [31:0] val;
   } exp_t;

   exp_t exp_q[$];
   int   tests = 0;
   int   fails = 0;

   logic [7:0] glyph_tab [16] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
                                  8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71};

   // Reference model state: edges since reset release and the value the CPU last stored.
   int          edges = 0;
   logic [31:0] model_val = '0;

   function automatic int nib(logic [31:0] v, int d);
      return int'((v >> (4 * d)) & 32'hF);
   endfunction

   function automatic logic [7:0] model_byte(logic [31:0] v, int d, bit lz);
      int m = 0;
      for (int k = 0; k < 8; k++) if (nib(v, k) != 0) m = k;
      if (lz && d > m) return 8'h00;
      return glyph_tab[nib(v, d)];
   endfunction

   // One clock: present inputs, let the edge happen, record what the outputs must
   // show right after it. The pair lit after edge e reflects everything before e.
   task automatic step(input logic s, input logic [31:0] d);
      exp_t e;
      int   p;
      seg_ctrl   = s;
      write_data = d;
      @(posedge clk);
      edges++;
      p     = ((edges - 1) / Div) % 4;
      e.an  = (8'd1 << p) | (8'd1 << (p + 4));
      e.b0  = model_byte(model_val, p, 1'b1);
      e.b1  = model_byte(model_val, p + 4, 1'b1);
      e.n0  = model_byte(model_val, p, 1'b0);
      e.n1  = model_byte(model_val, p + 4, 1'b0);
      if (s) model_val = d;
      e.val = model_val;
      exp_q.push_back(e);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, $urandom);
   endtask

   // Assert reset between edges, check the display goes dark at once, then release.
   task automatic do_reset();
      #1;
      rst_n = 1'b0;
      exp_q.delete();
      #1;
      tests++;
      if ({an_b, o0_b, o1_b, val_b, an_n, o0_n, o1_n, val_n} != '0) begin
         fails++;
         $display("FAIL reset_dark: got an=%h o0=%h o1=%h val=%h / an=%h o0=%h o1=%h val=%h want 0",
                  an_b, o0_b, o1_b, val_b, an_n, o0_n, o1_n, val_n);
      end
      seg_ctrl = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst_n     = 1'b1;
      edges     = 0;
      model_val = '0;
   endtask

   // Monitor: outputs are presented every cycle; compare on the falling edge.
   always @(negedge clk) begin
      exp_t e;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         tests++;
         if (an_b !== e.an || o0_b !== e.b0 || o1_b !== e.b1 || val_b !== e.val) begin
            fails++;
            $display("FAIL scan_blank t=%0t: got an=%h o0=%h o1=%h val=%h want an=%h o0=%h o1=%h val=%h",
                     $time, an_b, o0_b, o1_b, val_b, e.an, e.b0, e.b1, e.val);
         end
         tests++;
         if (an_n !== e.an || o0_n !== e.n0 || o1_n !== e.n1 || val_n !== e.val) begin
            fails++;
            $display("FAIL scan_all t=%0t: got an=%h o0=%h o1=%h val=%h want an=%h o0=%h o1=%h val=%h",
                     $time, an_n, o0_n, o1_n, val_n, e.an, e.n0, e.n1, e.val);
         end
      end
   end

   initial begin
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;

      // Mid-frame reset, then a clean restart (first pair lit must be 8'h11).
      idle(6);
      do_reset();
      step(1'b0, 32'h0);
      tests++;
      if (an_b !== 8'h11) begin
         fails++;
         $display("FAIL first_pair: got %h want 11", an_b);
      end

      step(1'b1, 32'h1234_ABCD);
      idle(20);
      step(1'b1, 32'h0000_00F0);
      idle(16);
      step(1'b1, 32'h0);
      idle(16);

      // Back-to-back stores: last one wins.
      step(1'b1, 32'hAAAA_AAAA);
      step(1'b1, 32'h5555_5555);
      idle(8);

      // Stores landing exactly on the divider wrap edge.
      for (int r = 0; r < 4; r++) begin
         while ((edges % Div) != Div - 1) step(1'b0, $urandom);
         step(1'b1, $urandom >> (4 * $urandom_range(0, 7)));
         idle(6);
      end

      // Data bus noise with no strobe must not disturb the held value.
      idle(1000);

      // Random stores with varied leading-zero counts.
      for (int i = 0; i < 1500; i++) begin
         step(($urandom_range(0, 3) == 0), $urandom >> (4 * $urandom_range(0, 7)));
      end

      do_reset();
      for (int i = 0; i < 200; i++) begin
         step(($urandom_range(0, 2) == 0), $urandom >> (4 * $urandom_range(0, 7)));
      end

      @(negedge clk);
      @(negedge clk);
      tests++;
      if (exp_q.size() != 0) begin
         fails++;
         $display("FAIL drain: got %0d pending want 0", exp_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
